// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources in, stage enables/flushes and status out.
interface hazard_ctrl_if;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        id_rs2_used;
   logic        id_jump;
   logic        ex_load;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic        mem_access;
   logic        mem_ack;

   logic        pc_en;
   logic        if_id_en;
   logic        if_id_flush;
   logic        id_ex_en;
   logic        id_ex_flush;
   logic        ex_mem_en;
   logic        mem_wb_flush;
   logic        mem_req;
   logic [1:0]  state;
   logic [15:0] stall_count;
   logic        mem_timeout_err;

   modport master (
      output id_rs1, id_rs2, id_rs2_used, id_jump, ex_load, ex_rd,
             ex_redirect, mem_access, mem_ack,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_flush, mem_req, state, stall_count,
             mem_timeout_err
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs2_used, id_jump, ex_load, ex_rd,
             ex_redirect, mem_access, mem_ack,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_en, mem_wb_flush, mem_req, state, stall_count,
             mem_timeout_err
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, redirect/jump flush,
// and a memory-wait FSM that freezes the pipeline with a bounded timeout.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [1:0]  state_r, state_nxt;
   logic [7:0]  wcnt_r, wcnt_nxt;
   logic [15:0] stall_r;
   logic        err_r;

   logic load_use;
   logic n_pc_en, n_if_id_en, n_if_id_flush, n_id_ex_flush;
   logic freeze, wb_flush, err_set;
   logic pc_en_c;

   assign load_use = hz.ex_load && (hz.ex_rd != 5'd0) &&
                     ((hz.ex_rd == hz.id_rs1) ||
                      (hz.id_rs2_used && (hz.ex_rd == hz.id_rs2)));

   // Normal step: redirect outranks load-use, which outranks an ID jump.
   always_comb begin
      n_pc_en       = 1'b1;
      n_if_id_en    = 1'b1;
      n_if_id_flush = 1'b0;
      n_id_ex_flush = 1'b0;
      if (hz.ex_redirect) begin
         n_if_id_flush = 1'b1;
         n_id_ex_flush = 1'b1;
      end else if (load_use) begin
         n_pc_en       = 1'b0;
         n_if_id_en    = 1'b0;
         n_id_ex_flush = 1'b1;
      end else if (hz.id_jump) begin
         n_if_id_flush = 1'b1;
      end
   end

   always_comb begin
      freeze    = 1'b0;
      wb_flush  = 1'b0;
      err_set   = 1'b0;
      state_nxt = state_r;
      wcnt_nxt  = wcnt_r;
      case (state_r)
         RUN: begin
            if (hz.mem_access && !hz.mem_ack) begin
               freeze    = 1'b1;
               state_nxt = MEM_WAIT;
               wcnt_nxt  = 8'd0;
            end
         end
         MEM_WAIT: begin
            // Ack wins over a timeout landing in the same cycle.
            if (hz.mem_ack) begin
               state_nxt = RUN;
            end else if (wcnt_r == WAIT_LAST) begin
               err_set   = 1'b1;
               wb_flush  = 1'b1;
               state_nxt = RUN;
            end else begin
               freeze   = 1'b1;
               wcnt_nxt = wcnt_r + 8'd1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // While frozen every hazard source is masked; the held EX instruction re-raises it on exit.
   assign pc_en_c         = !freeze && n_pc_en;
   assign hz.pc_en        = pc_en_c;
   assign hz.if_id_en     = !freeze && n_if_id_en;
   assign hz.if_id_flush  = !freeze && n_if_id_flush;
   assign hz.id_ex_en     = !freeze;
   assign hz.id_ex_flush  = !freeze && n_id_ex_flush;
   assign hz.ex_mem_en    = !freeze;
   assign hz.mem_wb_flush = freeze || wb_flush;
   assign hz.mem_req      = (state_r != RUN) || hz.mem_access;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= RUN;
         wcnt_r  <= 8'd0;
         stall_r <= 16'd0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt;
         wcnt_r  <= wcnt_nxt;
         if (!pc_en_c && (stall_r != 16'hFFFF))
            stall_r <= stall_r + 16'd1;
         if (err_set)
            err_r <= 1'b1;
      end
   end

   assign hz.state           = state_r;
   assign hz.stall_count     = stall_r;
   assign hz.mem_timeout_err = err_r;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port id_rs1  input  5  ID-stage source register 1.
REQ-005 SHALL have port id_rs2  input  5  ID-stage source register 2.
REQ-006 SHALL have port id_rs2_used  input  1  ID instruction reads id_rs2 (R-type, store, branch).
REQ-007 SHALL have port id_jump  input  1  ID-stage J/JAL (PC redirect decided in ID).
REQ-008 SHALL have port ex_load  input  1  EX-stage instruction is a load word.
REQ-009 SHALL have port ex_rd  input  5  EX-stage destination register.
REQ-010 SHALL have port ex_redirect  input  1  EX-stage taken branch, JR or JALR.
REQ-011 SHALL have port mem_access  input  1  MEM-stage instruction is load/store.
REQ-012 SHALL have port mem_ack  input  1  data memory completes access this cycle.
REQ-013 SHALL have port pc_en  output  1  PC register load enable.
REQ-014 SHALL have port if_id_en  output  1  IF/ID register enable.
REQ-015 SHALL have port if_id_flush  output  1  IF/ID loads bubble.
REQ-016 SHALL have port id_ex_en  output  1  ID/EX register enable.
REQ-017 SHALL have port id_ex_flush  output  1  ID/EX loads bubble.
REQ-018 SHALL have port ex_mem_en  output  1  EX/MEM register enable.
REQ-019 SHALL have port mem_wb_flush  output  1  MEM/WB loads bubble.
REQ-020 SHALL have port mem_req  output  1  data memory request.
REQ-021 SHALL have port state  output  2  FSM state, RUN=0, MEM_WAIT=1.
REQ-022 SHALL have port stall_count  output  16  cycles with pc_en=0, saturating.
REQ-023 SHALL have port mem_timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-024 SHALL define load_use = ex_load & ex_rd!=0 & (ex_rd==id_rs1 | (id_rs2_used & ex_rd==id_rs2)).
REQ-025 SHALL define "normal step" by priority: ex_redirect -> pc_en=1, if_id_flush=1, id_ex_flush=1; else load_use -> pc_en=0, if_id_en=0, id_ex_flush=1; else id_jump -> pc_en=1, if_id_flush=1; else no flush; unlisted enables=1, flushes=0.
REQ-026 SHALL ignore load_use and id_jump when ex_redirect is high in the same cycle.
REQ-027 SHALL, in RUN with mem_access & mem_ack, perform a normal step with zero-cycle penalty and stay in RUN.
REQ-028 SHALL, in RUN with mem_access & !mem_ack, freeze pipeline (pc_en, if_id_en, id_ex_en, ex_mem_en = 0; flushes 0 except mem_wb_flush=1), clear wait counter, next state MEM_WAIT.
REQ-029 SHALL, in RUN with !mem_access, perform a normal step.
REQ-030 SHALL drive mem_req = mem_access in RUN and 1 in MEM_WAIT.
REQ-031 SHALL, in MEM_WAIT without mem_ack, hold the freeze of REQ-028 and increment the 8-bit wait counter.
REQ-032 SHALL, in MEM_WAIT with mem_ack, perform a normal step (mem_wb_flush=0) and return to RUN.
REQ-033 SHALL, in MEM_WAIT when wait counter == MEM_TIMEOUT-1 and !mem_ack, set mem_timeout_err, perform a normal step with mem_wb_flush=1, return to RUN.
REQ-034 SHALL give mem_ack priority over timeout in the same cycle.
REQ-035 SHALL ignore ex_redirect, load_use, id_jump during frozen MEM_WAIT cycles; the frozen EX instruction re-presents them on exit.
REQ-036 SHALL increment stall_count on every cycle with pc_en=0, saturating at 0xFFFF.
REQ-037 SHALL compute all outputs except state, stall_count, mem_timeout_err combinationally from inputs and current state.

Reset
REQ-038 SHALL, while reset=1 at a clock edge, load state=RUN, wait counter=0, stall_count=0, mem_timeout_err=0, regardless of current state (including mid-MEM_WAIT); combinational outputs follow RUN rules from the next cycle.

Verification
REQ-039 SHALL cover load-use: ex_load=1, ex_rd=5, id_rs1=5 -> pc_en=0, if_id_en=0, id_ex_flush=1 one cycle; stall_count 0->1.
REQ-040 SHALL cover ex_rd=0 with id_rs1=0, ex_load=1 -> no stall, all enables 1.
REQ-041 SHALL cover ex_redirect=1 with load_use=1 and id_jump=1 -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall.
REQ-042 SHALL cover mem_access=1, mem_ack low 3 cycles then high -> state=1 for 3 cycles, mem_wb_flush=1 for 3 cycles, RUN on ack, stall_count=3.
REQ-043 SHALL cover MEM_TIMEOUT=4, mem_ack never -> exit after 4 frozen cycles, mem_timeout_err=1 until reset.
REQ-044 SHALL cover reset asserted in 2nd MEM_WAIT cycle -> state=0, stall_count=0, mem_timeout_err=0 next cycle.
